// File: rtl/rs_enc_block_sched.sv
// rs_enc_block_sched
// Block scheduler placed in front of the Atlantic RS encoder sink.
// Per-block descriptors {codeword length n, check count} are validated and
// queued. Each queued block is then streamed from upstream to the encoder
// with sop/eop framing and a numcheck value that stays constant for the
// whole block. The number of codewords in flight is limited by counting
// the eops seen at the encoder output.
//
// Ports
//   clk_int, reset_int            clock (rising edge), async active-low reset
//   desc_wr/desc_len/desc_numcheck descriptor write strobe and fields
//   desc_full, desc_err           queue full; one-cycle reject/drop pulse
//   up_val/up_data/up_rdy         upstream symbol handshake
//   enc_ena                       encoder sink ready
//   enc_val/sop/eop/data          encoder sink symbol stream
//   enc_numcheck                  check count of the current block
//   enc_out_val/enc_out_eop       encoder source side, for in-flight tracking
//   busy                          scheduler has work pending or in flight
//   blocks_in/blocks_out          wrapping eop counts, sent and received
module rs_enc_block_sched #(
    parameter int M          = 4,
    parameter int CHECK      = 6,
    parameter int WIDE       = 3,
    parameter int LEN_W      = 8,
    parameter int DESC_DEPTH = 4,
    parameter int MAX_OUT    = 3
) (
    input  logic             clk_int,
    input  logic             reset_int,
    input  logic             desc_wr,
    input  logic [LEN_W-1:0] desc_len,
    input  logic [WIDE-1:0]  desc_numcheck,
    output logic             desc_full,
    output logic             desc_err,
    input  logic             up_val,
    input  logic [M-1:0]     up_data,
    output logic             up_rdy,
    input  logic             enc_ena,
    output logic             enc_val,
    output logic             enc_sop,
    output logic             enc_eop,
    output logic [M-1:0]     enc_data,
    output logic [WIDE-1:0]  enc_numcheck,
    input  logic             enc_out_val,
    input  logic             enc_out_eop,
    output logic             busy,
    output logic [15:0]      blocks_in,
    output logic [15:0]      blocks_out
);

    localparam int AW = $clog2(DESC_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t          state;
    logic [M-1:0]    k_mem  [DESC_DEPTH];
    logic [WIDE-1:0] nc_mem [DESC_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [M-1:0]    kreg;
    logic [M-1:0]    sym_cnt;

    logic            queue_full;
    logic            queue_empty;
    logic            push;
    logic            pop;
    logic            in_send;
    logic            xfer;
    logic            last_sym;
    logic [M-1:0]    k_new;
    logic [15:0]     inflight;

    // A descriptor is usable only if it carries 1..CHECK check symbols,
    // fits in a codeword of 2^M-1 symbols, and leaves at least one
    // message symbol.
    function automatic logic desc_ok(input logic [LEN_W-1:0] len,
                                     input logic [WIDE-1:0]  nc);
        desc_ok = (nc != '0) &&
                  (int'(nc) <= CHECK) &&
                  (int'(len) <= (2 ** M) - 1) &&
                  (int'(len) > int'(nc));
    endfunction

    // For accepted descriptors len fits in M bits, so the low bits give k.
    assign k_new       = desc_len[M-1:0] - M'(desc_numcheck);
    assign queue_full  = (count == CW'(DESC_DEPTH));
    assign queue_empty = (count == '0);
    assign inflight    = blocks_in - blocks_out;

    // Overflow uses the current occupancy, so a same-cycle pop does not
    // rescue a write into a full queue.
    assign push = desc_wr && desc_ok(desc_len, desc_numcheck) && !queue_full;
    assign pop  = (state == LOAD) && !queue_empty && (inflight < 16'(MAX_OUT));

    assign in_send  = (state == SEND);
    assign xfer     = in_send && up_val && enc_ena;
    assign last_sym = (sym_cnt == kreg - 1'b1);

    // Sink side is a straight pass-through while a block is being sent.
    assign enc_val   = in_send && up_val;
    assign enc_sop   = enc_val && (sym_cnt == '0);
    assign enc_eop   = enc_val && last_sym;
    assign enc_data  = in_send ? up_data : '0;
    assign up_rdy    = in_send && enc_ena;
    assign desc_full = queue_full;
    assign busy      = (state != IDLE) || !queue_empty || (inflight != '0);

    // Descriptor storage holds data only; validity is tracked by count.
    always_ff @(posedge clk_int) begin
        if (push) begin
            k_mem[wr_ptr]  <= k_new;
            nc_mem[wr_ptr] <= desc_numcheck;
        end
    end

    always_ff @(posedge clk_int or negedge reset_int) begin
        if (!reset_int) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            kreg         <= '0;
            sym_cnt      <= '0;
            enc_numcheck <= '0;
            blocks_in    <= '0;
            blocks_out   <= '0;
            desc_err     <= 1'b0;
        end else begin
            desc_err <= desc_wr && (!desc_ok(desc_len, desc_numcheck) || queue_full);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);

            // Both counters may step in the same cycle; inflight is their
            // difference, so that case leaves it unchanged.
            if (enc_out_val && enc_out_eop) begin
                blocks_out <= blocks_out + 1'b1;
            end
            if (xfer && last_sym) begin
                blocks_in <= blocks_in + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!queue_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (queue_empty) begin
                        state <= IDLE;
                    end else if (pop) begin
                        kreg         <= k_mem[rd_ptr];
                        enc_numcheck <= nc_mem[rd_ptr];
                        sym_cnt      <= '0;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        sym_cnt <= sym_cnt + 1'b1;
                        if (last_sym) begin
                            state <= queue_empty ? IDLE : LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_enc_block_sched.sv
// tb_rs_enc_block_sched
// Self-checking bench for rs_enc_block_sched. A queue-based model of the
// accepted blocks predicts framing, numcheck, counters and busy for every
// cycle; directed sections add latency, gap, in-flight and reset checks,
// followed by a randomized traffic phase.
module tb_rs_enc_block_sched;

    localparam int M          = 4;
    localparam int CHECK      = 6;
    localparam int WIDE       = 3;
    localparam int LEN_W      = 8;
    localparam int DESC_DEPTH = 4;
    localparam int MAX_OUT    = 3;

    logic             clk_int = 1'b0;
    logic             reset_int;
    logic             desc_wr;
    logic [LEN_W-1:0] desc_len;
    logic [WIDE-1:0]  desc_numcheck;
    logic             desc_full;
    logic             desc_err;
    logic             up_val;
    logic [M-1:0]     up_data;
    logic             up_rdy;
    logic             enc_ena;
    logic             enc_val;
    logic             enc_sop;
    logic             enc_eop;
    logic [M-1:0]     enc_data;
    logic [WIDE-1:0]  enc_numcheck;
    logic             enc_out_val;
    logic             enc_out_eop;
    logic             busy;
    logic [15:0]      blocks_in;
    logic [15:0]      blocks_out;

    always #5 clk_int = ~clk_int;

    rs_enc_block_sched #(
        .M(M), .CHECK(CHECK), .WIDE(WIDE), .LEN_W(LEN_W),
        .DESC_DEPTH(DESC_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_int(clk_int), .reset_int(reset_int),
        .desc_wr(desc_wr), .desc_len(desc_len), .desc_numcheck(desc_numcheck),
        .desc_full(desc_full), .desc_err(desc_err),
        .up_val(up_val), .up_data(up_data), .up_rdy(up_rdy),
        .enc_ena(enc_ena), .enc_val(enc_val), .enc_sop(enc_sop), .enc_eop(enc_eop),
        .enc_data(enc_data), .enc_numcheck(enc_numcheck),
        .enc_out_val(enc_out_val), .enc_out_eop(enc_out_eop),
        .busy(busy), .blocks_in(blocks_in), .blocks_out(blocks_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: blocks accepted but not yet completed, oldest first.
    int mq_k[$];
    int mq_nc[$];
    int mon_pos   = 0;
    bit sop_seen  = 0;
    int exp_in    = 0;
    int exp_out   = 0;
    bit last_xfer = 0;
    int sop_log[$];
    int eop_log[$];
    int out_cyc   = 0;

    bit rnd       = 0;
    bit bp        = 0;
    bit auto_out  = 1;
    bit man_pulse = 0;
    int stalls    = 0;
    int wr_cyc    = 0;
    int nvalid    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_int);
            #1;
        end
    endtask

    task automatic write_desc(input int len, input int nc, input bit exp_err);
        desc_len      = LEN_W'(len);
        desc_numcheck = WIDE'(nc);
        desc_wr       = 1'b1;
        wr_cyc        = cyc;
        if (!exp_err) begin
            mq_k.push_back(len - nc);
            mq_nc.push_back(nc);
        end
        tick(1);
        desc_wr = 1'b0;
        chk("desc_err", desc_err, exp_err);
    endtask

    task automatic wait_eops(input int n);
        int t;
        t = 0;
        while (eop_log.size() < n && t < 2000) begin
            tick(1);
            t++;
        end
        chk("wait_eops", eop_log.size() >= n, 1);
    endtask

    task automatic wait_sops(input int n);
        int t;
        t = 0;
        while (sop_log.size() < n && t < 2000) begin
            tick(1);
            t++;
        end
        chk("wait_sops", sop_log.size() >= n, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((mq_k.size() != 0 || exp_in != exp_out) && t < 4000) begin
            tick(1);
            t++;
        end
        tick(2);
        chk("idle_busy", busy, 0);
    endtask

    task automatic clear_logs();
        sop_log.delete();
        eop_log.delete();
    endtask

    initial forever begin
        @(posedge clk_int);
        cyc++;
    end

    // Upstream source, encoder-ready and encoder-output drivers.
    initial forever begin
        bit ap;
        @(posedge clk_int);
        #1;
        if (!up_val || last_xfer) begin
            up_val  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            up_data = M'($urandom);
        end
        if (rnd) begin
            enc_ena = ($urandom_range(0, 3) != 0);
        end else if (bp && mon_pos == 3 && stalls < 5) begin
            enc_ena = 1'b0;
            stalls++;
        end else begin
            enc_ena = 1'b1;
        end
        ap = auto_out && (exp_in - exp_out) > 0 && ($urandom_range(0, 2) == 0);
        enc_out_eop = ap | man_pulse;
        enc_out_val = enc_out_eop | (rnd && $urandom_range(0, 4) == 0);
    end

    // Cycle monitor: compare against the model, then advance it.
    initial forever begin
        @(negedge clk_int);
        if (!reset_int) begin
            mq_k.delete();
            mq_nc.delete();
            mon_pos   = 0;
            sop_seen  = 0;
            exp_in    = 0;
            exp_out   = 0;
            last_xfer = 0;
            chk("rst_enc_val", enc_val, 0);
        end else begin
            chk("blocks_in", blocks_in, exp_in & 32'hFFFF);
            chk("blocks_out", blocks_out, exp_out & 32'hFFFF);
            chk("busy", busy, (mq_k.size() != 0) || (exp_in != exp_out));
            if (!enc_val) begin
                chk("sop_gate", enc_sop, 0);
                chk("eop_gate", enc_eop, 0);
            end else if (mq_k.size() == 0) begin
                chk("stray_val", enc_val, 0);
            end else begin
                chk("sop", enc_sop, mon_pos == 0);
                chk("eop", enc_eop, mon_pos == mq_k[0] - 1);
                chk("numcheck", enc_numcheck, mq_nc[0]);
                chk("data", enc_data, up_data);
                chk("up_rdy", up_rdy, enc_ena);
                if (mon_pos == 0 && !sop_seen) begin
                    sop_seen = 1;
                    sop_log.push_back(cyc);
                    chk("inflight_cap", (exp_in - exp_out) < MAX_OUT, 1);
                end
                if (enc_ena) begin
                    mon_pos++;
                    if (mon_pos == mq_k[0]) begin
                        void'(mq_k.pop_front());
                        void'(mq_nc.pop_front());
                        exp_in++;
                        mon_pos  = 0;
                        sop_seen = 0;
                        eop_log.push_back(cyc);
                    end
                end
            end
            last_xfer = up_val & up_rdy;
            if (enc_out_val & enc_out_eop) begin
                exp_out++;
                out_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_int     = 1'b0;
        desc_wr       = 1'b0;
        desc_len      = '0;
        desc_numcheck = '0;
        up_val        = 1'b0;
        up_data       = '0;
        enc_ena       = 1'b0;
        enc_out_val   = 1'b0;
        enc_out_eop   = 1'b0;
        tick(3);

        // Reset state
        chk("rst_val", enc_val, 0);
        chk("rst_sop", enc_sop, 0);
        chk("rst_eop", enc_eop, 0);
        chk("rst_rdy", up_rdy, 0);
        chk("rst_data", enc_data, 0);
        chk("rst_full", desc_full, 0);
        chk("rst_err", desc_err, 0);
        chk("rst_nc", enc_numcheck, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bin", blocks_in, 0);
        chk("rst_bout", blocks_out, 0);
        reset_int = 1'b1;
        tick(2);

        // Single block n=15, numcheck=6
        clear_logs();
        write_desc(15, 6, 0);
        wait_eops(1);
        chk("t1_latency", sop_log[0] - (wr_cyc + 1), 2);
        chk("t1_len", eop_log[0] - sop_log[0], 8);
        tick(1);
        chk("t1_blocks_in", blocks_in, 1);
        wait_idle();

        // Three blocks back to back
        clear_logs();
        write_desc(15, 4, 0);
        write_desc(10, 2, 0);
        write_desc(7, 6, 0);
        wait_eops(3);
        chk("t2_gap1", sop_log[1] - eop_log[0], 2);
        chk("t2_gap2", sop_log[2] - eop_log[1], 2);
        chk("t2_len1", eop_log[0] - sop_log[0], 10);
        chk("t2_len2", eop_log[1] - sop_log[1], 7);
        chk("t2_k1_same", eop_log[2] - sop_log[2], 0);
        tick(1);
        chk("t2_blocks_in", blocks_in, 4);
        wait_idle();

        // Rejections
        clear_logs();
        write_desc(15, 7, 1);
        write_desc(15, 0, 1);
        write_desc(6, 6, 1);
        write_desc(16, 4, 1);
        tick(1);
        chk("rej_err_clear", desc_err, 0);
        tick(4);
        chk("rej_busy", busy, 0);
        chk("rej_full", desc_full, 0);
        chk("rej_nosop", sop_log.size(), 0);

        // In-flight limit, queue overflow
        clear_logs();
        auto_out = 0;
        repeat (5) write_desc(5, 2, 0);
        wait_eops(3);
        tick(10);
        chk("t4_parked_sops", sop_log.size(), 3);
        chk("t4_blocks_in", blocks_in, 7);
        chk("t4_busy", busy, 1);
        write_desc(5, 2, 0);
        write_desc(5, 2, 0);
        chk("t4_full", desc_full, 1);
        write_desc(5, 2, 1);
        chk("t4_full_hold", desc_full, 1);
        man_pulse = 1;
        tick(1);
        man_pulse = 0;
        wait_sops(4);
        chk("t4_resume", (sop_log.size() >= 4) ? sop_log[3] - out_cyc : -1, 2);
        wait_eops(4);
        tick(8);
        chk("t4_reparked", sop_log.size(), 4);
        chk("t4_full_after_pop", desc_full, 0);
        auto_out = 1;
        wait_idle();
        chk("t4_all_sops", sop_log.size(), 7);
        chk("t4_blocks_in_end", blocks_in, 11);

        // Backpressure on symbol 4 of k=9
        clear_logs();
        stalls = 0;
        bp     = 1;
        write_desc(15, 6, 0);
        wait_eops(1);
        bp = 0;
        chk("bp_len", eop_log[0] - sop_log[0], 13);
        wait_idle();
        chk("bp_blocks_in", blocks_in, 12);

        // Randomized traffic
        rnd    = 1;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            int len;
            int nc;
            int t;
            bit ok;
            t = 0;
            while (mq_k.size() > 2 && t < 1000) begin
                tick(1);
                t++;
            end
            len = $urandom_range(0, 20);
            nc  = $urandom_range(0, 7);
            ok  = (nc != 0) && (nc <= CHECK) && (len <= 15) && (len > nc);
            write_desc(len, nc, !ok);
            if (ok) nvalid++;
            tick($urandom_range(0, 3));
        end
        wait_idle();
        rnd = 0;
        tick(2);
        chk("rnd_blocks_in", blocks_in, 12 + nvalid);

        // Reset in the middle of a block
        clear_logs();
        write_desc(15, 6, 0);
        begin
            int t;
            t = 0;
            while (mon_pos != 4 && t < 200) begin
                tick(1);
                t++;
            end
            chk("rst_mid_reach", mon_pos, 4);
        end
        reset_int = 1'b0;
        #1;
        chk("rstm_val", enc_val, 0);
        chk("rstm_sop", enc_sop, 0);
        chk("rstm_eop", enc_eop, 0);
        chk("rstm_rdy", up_rdy, 0);
        chk("rstm_data", enc_data, 0);
        chk("rstm_nc", enc_numcheck, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_bin", blocks_in, 0);
        chk("rstm_bout", blocks_out, 0);
        chk("rstm_full", desc_full, 0);
        tick(3);
        reset_int = 1'b1;
        tick(2);
        clear_logs();
        write_desc(10, 2, 0);
        wait_eops(1);
        chk("rstm_new_sop", sop_log.size(), 1);
        chk("rstm_new_len", eop_log[0] - sop_log[0], 7);
        tick(1);
        chk("rstm_blocks_in", blocks_in, 1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
